lfsr_pattern_counter: RTL and testbench
=======================================

// Module: lfsr_pattern_counter
// PURPOSE
//  Parametrised pseudo-random pattern counter: a Fibonacci LFSR generates a serial bit stream.
//  A P-bit pattern detector (overlapping or non-overlapping mode) counts pattern hits in a
//  D-digit BCD counter. At every period boundary the count is latched for the display mux,
//  then the live count is cleared. Advances on a single-cycle tick enable from the clock divider.
// PARAMETERS
//  W        4        LFSR width in bits (2..32)
//  TAPS     4'b1100  feedback mask; fb = XOR of state bits where TAPS=1 (x^4+x^3+1 default)
//  SEED     4'b0001  LFSR value loaded at reset; SEED==0 is replaced by 1
//  P        2        pattern length in bits (1..16)
//  PATTERN  2'b11    pattern; MSB = oldest bit
//  OVERLAP  1        1 = overlapping matches counted; 0 = history restarts after each match
//  D        4        BCD digits in counters (1..8)
//  PERIOD   15       ticks per counting period (default 2^W-1), >=1
// PORTS
//  clk          in   1    system clock
//  reset        in   1    synchronous, active-high reset
//  tick         in   1    advance enable, one clk wide; all state holds when 0
//  lfsr_state   out  W    current LFSR register
//  serial_bit   out  1    lfsr_state[W-1]; bit consumed on next tick
//  match        out  1    one-clk pulse after the tick that completed the pattern
//  live_bcd     out  4*D  running BCD count, digit 0 in [3:0]
//  live_ovf     out  1    live count saturated this period
//  result_bcd   out  4*D  count latched at last period end
//  result_ovf   out  1    live_ovf latched at last period end
//  period_done  out  1    one-clk pulse after the tick that ended a period
// BEHAVIOUR
//  - Reset (sync): lfsr_state=SEED (1 if SEED==0); history, seen counter, period counter,
//    live_bcd, live_ovf, result_bcd, result_ovf, match, period_done = 0. Reset overrides tick.
//  - Registered outputs update only on a clk edge with tick=1. match and period_done are 0
//    on any edge without tick.
//  - LFSR: next = {state[W-2:0], ^(state & TAPS)}. If state is ever all-zero, the next tick
//    loads SEED instead (lockup recovery).
//  - Detector: hist_n = {hist[P-2:0], serial_bit}, seen_n = min(seen+1, P).
//    hit = (hist_n==PATTERN) && (seen_n==P). Edge stores hist_n, seen_n, match<=hit.
//    OVERLAP=0 with hit: seen <= 0, so the next P bits must be fresh.
//  - Latency: count, match, and period_done are visible the cycle after the tick edge.
//  - BCD count: on hit, ripple +1 with per-digit carry 9->0. If already all-9s: hold, live_ovf<=1.
//  - Period counter 0..PERIOD-1. Tick at PERIOD-1 wraps it to 0 and pulses period_done.
//    result_bcd/result_ovf <= live value including this tick's hit.
//    live_bcd <= 0 and live_ovf <= 0, even if this tick hits: the hit goes to result only.
//  - Detector history and seen are NOT cleared at period end. Matches spanning the boundary
//    count in the new period.
//  - Reset mid-period discards the live count and the result. No period_done is emitted.
// TESTING (defaults unless stated; bit stream from reset = 000100110101111, repeating)
//  1. reset, 15 ticks -> lfsr_state returns to 4'b0001, match pulses after ticks 8,13,14,15;
//     period_done after tick 15, result_bcd=16'h0004, live_bcd=0.
//  2. OVERLAP=0, 15 ticks -> match after ticks 8,13,15; result_bcd=16'h0003.
//  3. D=1, P=1, PATTERN=1'b1, PERIOD=30, 30 ticks -> live_bcd reaches 4'h9 then holds,
//     live_ovf=1; result_bcd=4'h9, result_ovf=1, live cleared.
//  4. tick held 0 for 20 clks mid-period -> all outputs unchanged, no match/period_done pulses.
//  5. reset asserted after 10 ticks with tick=1 -> next clk: lfsr_state=4'b0001, live_bcd=0,
//     result_bcd=0, no period_done; 15 further ticks reproduce scenario 1.
//  6. SEED=0 -> after reset lfsr_state=4'b0001; force state 0 via bench -> next tick reloads 4'b0001.

Source files
------------

// File: rtl/lfsr_pattern_counter.sv
// lfsr_pattern_counter
//   A Fibonacci LFSR produces a serial bit stream. A P-bit pattern detector counts hits in a
//   D-digit BCD counter. At every period boundary the live count is latched into the result
//   registers and then cleared. All state advances only on a single-cycle tick enable.
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset; takes priority over tick
//   tick         advance enable, one clk wide
//   lfsr_state   current LFSR register
//   serial_bit   lfsr_state[W-1]; this bit is consumed on the next tick
//   match        one-clk pulse after the tick that completed the pattern
//   live_bcd     running BCD hit count, digit 0 in [3:0]
//   live_ovf     live count saturated at all-9s during this period
//   result_bcd   count latched at the last period end
//   result_ovf   live_ovf latched at the last period end
//   period_done  one-clk pulse after the tick that ended a period
module lfsr_pattern_counter #(
  parameter int unsigned   W       = 4,
  parameter logic [W-1:0]  TAPS    = 4'b1100,
  parameter logic [W-1:0]  SEED    = 4'b0001,
  parameter int unsigned   P       = 2,
  parameter logic [P-1:0]  PATTERN = 2'b11,
  parameter bit            OVERLAP = 1'b1,
  parameter int unsigned   D       = 4,
  parameter int unsigned   PERIOD  = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  output logic [W-1:0]   lfsr_state,
  output logic           serial_bit,
  output logic           match,
  output logic [4*D-1:0] live_bcd,
  output logic           live_ovf,
  output logic [4*D-1:0] result_bcd,
  output logic           result_ovf,
  output logic           period_done
);

  localparam int unsigned SW = $clog2(P + 1);
  localparam int unsigned PW = $clog2(PERIOD + 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0]   lfsr_q, lfsr_d;
  logic [P-1:0]   hist_q, hist_d;
  logic [SW-1:0]  seen_q, seen_d;
  logic [PW-1:0]  per_q;
  logic [4*D-1:0] live_q, live_d, inc_bcd, result_q;
  logic           live_ovf_q, live_ovf_d, result_ovf_q;
  logic           match_q, pdone_q;
  logic           hit, all_nines, carry, period_end;

  // LFSR next state with lockup recovery.
  always_comb begin
    if (lfsr_q == '0) begin
      lfsr_d = SEED_EFF;
    end else begin
      lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
    end
  end

  // Detector: shift form avoids a negative slice when P == 1.
  always_comb begin
    hist_d = (hist_q << 1) | P'(lfsr_q[W-1]);
    seen_d = (seen_q == SW'(P)) ? seen_q : seen_q + 1'b1;
    hit    = (hist_d == PATTERN) && (seen_d == SW'(P));
  end

  // Ripple BCD increment; carry surviving every digit means the count is all-9s.
  always_comb begin
    inc_bcd = live_q;
    carry   = 1'b1;
    for (int i = 0; i < int'(D); i++) begin
      if (carry) begin
        if (live_q[4*i +: 4] == 4'd9) begin
          inc_bcd[4*i +: 4] = 4'd0;
        end else begin
          inc_bcd[4*i +: 4] = live_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  always_comb begin
    live_d     = live_q;
    live_ovf_d = live_ovf_q;
    if (hit) begin
      if (all_nines) begin
        live_ovf_d = 1'b1;
      end else begin
        live_d = inc_bcd;
      end
    end
  end

  assign period_end = (per_q == PW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q       <= SEED_EFF;
      hist_q       <= '0;
      seen_q       <= '0;
      per_q        <= '0;
      live_q       <= '0;
      live_ovf_q   <= 1'b0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
      match_q      <= 1'b0;
      pdone_q      <= 1'b0;
    end else if (tick) begin
      lfsr_q  <= lfsr_d;
      hist_q  <= hist_d;
      // Non-overlapping mode forces P fresh bits before the next hit.
      seen_q  <= (hit && !OVERLAP) ? '0 : seen_d;
      match_q <= hit;
      if (period_end) begin
        per_q        <= '0;
        pdone_q      <= 1'b1;
        // This tick's hit lands in the result only; the new period starts from zero.
        result_q     <= live_d;
        result_ovf_q <= live_ovf_d;
        live_q       <= '0;
        live_ovf_q   <= 1'b0;
      end else begin
        per_q      <= per_q + 1'b1;
        pdone_q    <= 1'b0;
        live_q     <= live_d;
        live_ovf_q <= live_ovf_d;
      end
    end else begin
      match_q <= 1'b0;
      pdone_q <= 1'b0;
    end
  end

  assign lfsr_state  = lfsr_q;
  assign serial_bit  = lfsr_q[W-1];
  assign match       = match_q;
  assign live_bcd    = live_q;
  assign live_ovf    = live_ovf_q;
  assign result_bcd  = result_q;
  assign result_ovf  = result_ovf_q;
  assign period_done = pdone_q;

endmodule

// File: tb/tb_lfsr_pattern_counter.sv
// Directed bench for lfsr_pattern_counter. Four instances share clk/reset/tick:
//   a: defaults, b: OVERLAP=0, c: D=1 P=1 PATTERN=1 PERIOD=30, d: SEED=0.
module tb_lfsr_pattern_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  logic [3:0]  a_lfsr, b_lfsr, c_lfsr, d_lfsr;
  logic        a_sb, b_sb, c_sb, d_sb;
  logic        a_match, b_match, c_match, d_match;
  logic [15:0] a_live, b_live, d_live;
  logic [3:0]  c_live;
  logic        a_lovf, b_lovf, c_lovf, d_lovf;
  logic [15:0] a_res, b_res, d_res;
  logic [3:0]  c_res;
  logic        a_rovf, b_rovf, c_rovf, d_rovf;
  logic        a_pd, b_pd, c_pd, d_pd;

  // LFSR state after tick i (index i-1) from SEED=1, taps x^4+x^3+1.
  logic [3:0] exp_lfsr [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  // Serial stream 000100110101111: pattern 11 hits after these ticks.
  logic       m_ov  [15] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1};
  logic       m_nov [15] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1};

  lfsr_pattern_counter dut_a (
    .clk(clk), .reset(reset), .tick(tick), .lfsr_state(a_lfsr), .serial_bit(a_sb),
    .match(a_match), .live_bcd(a_live), .live_ovf(a_lovf), .result_bcd(a_res),
    .result_ovf(a_rovf), .period_done(a_pd)
  );

  lfsr_pattern_counter #(.OVERLAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .lfsr_state(b_lfsr), .serial_bit(b_sb),
    .match(b_match), .live_bcd(b_live), .live_ovf(b_lovf), .result_bcd(b_res),
    .result_ovf(b_rovf), .period_done(b_pd)
  );

  lfsr_pattern_counter #(.D(1), .P(1), .PATTERN(1'b1), .PERIOD(30)) dut_c (
    .clk(clk), .reset(reset), .tick(tick), .lfsr_state(c_lfsr), .serial_bit(c_sb),
    .match(c_match), .live_bcd(c_live), .live_ovf(c_lovf), .result_bcd(c_res),
    .result_ovf(c_rovf), .period_done(c_pd)
  );

  lfsr_pattern_counter #(.SEED(4'b0000)) dut_d (
    .clk(clk), .reset(reset), .tick(tick), .lfsr_state(d_lfsr), .serial_bit(d_sb),
    .match(d_match), .live_bcd(d_live), .live_ovf(d_lovf), .result_bcd(d_res),
    .result_ovf(d_rovf), .period_done(d_pd)
  );

  // Drive at negedge, let one posedge happen, return at the following negedge.
  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full default period on instance a, checked tick by tick.
  task automatic run_period_a(input string tag);
    int cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      step(1'b1);
      if (m_ov[i-1]) cnt++;
      total++;
      if (a_lfsr !== exp_lfsr[i-1])
        $display("FAIL %s lfsr tick %0d: got %h want %h", tag, i, a_lfsr, exp_lfsr[i-1]);
      else passed++;
      total++;
      if (a_match !== m_ov[i-1])
        $display("FAIL %s match tick %0d: got %b want %b", tag, i, a_match, m_ov[i-1]);
      else passed++;
      total++;
      if (a_pd !== (i == 15))
        $display("FAIL %s period_done tick %0d: got %b want %b", tag, i, a_pd, (i == 15));
      else passed++;
      total++;
      if (a_live !== ((i == 15) ? 16'h0000 : 16'(cnt)))
        $display("FAIL %s live_bcd tick %0d: got %h want %h", tag, i, a_live,
                 ((i == 15) ? 16'h0000 : 16'(cnt)));
      else passed++;
    end
    total++;
    if (a_res !== 16'h0004) $display("FAIL %s result_bcd: got %h want 0004", tag, a_res);
    else passed++;
    total++;
    if (a_rovf !== 1'b0) $display("FAIL %s result_ovf: got %b want 0", tag, a_rovf);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (a_lfsr !== 4'b0001) $display("FAIL reset lfsr: got %b want 0001", a_lfsr);
    else passed++;
    total++;
    if ({a_live, a_lovf, a_res, a_rovf} !== 34'd0)
      $display("FAIL reset counts: got live=%h lovf=%b res=%h rovf=%b want 0", a_live, a_lovf,
               a_res, a_rovf);
    else passed++;
    total++;
    if ({a_match, a_pd} !== 2'b00)
      $display("FAIL reset pulses: got match=%b pd=%b want 0 0", a_match, a_pd);
    else passed++;
  endtask

  task automatic test_overlap();
    do_reset();
    run_period_a("overlap");
  endtask

  task automatic test_non_overlap();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      step(1'b1);
      total++;
      if (b_match !== m_nov[i-1])
        $display("FAIL nonoverlap match tick %0d: got %b want %b", i, b_match, m_nov[i-1]);
      else passed++;
    end
    total++;
    if (b_res !== 16'h0003) $display("FAIL nonoverlap result_bcd: got %h want 0003", b_res);
    else passed++;
    total++;
    if ({b_pd, b_live} !== {1'b1, 16'h0000})
      $display("FAIL nonoverlap end: got pd=%b live=%h want 1 0000", b_pd, b_live);
    else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      step(1'b1);
      if (i == 15) begin
        total++;
        if (c_pd !== 1'b0) $display("FAIL sat early period_done: got %b want 0", c_pd);
        else passed++;
      end
      if (i == 19) begin
        total++;
        if ({c_live, c_lovf} !== {4'h9, 1'b0})
          $display("FAIL sat reach9: got live=%h ovf=%b want 9 0", c_live, c_lovf);
        else passed++;
      end
      if (i == 22) begin
        total++;
        if ({c_live, c_lovf} !== {4'h9, 1'b1})
          $display("FAIL sat hold: got live=%h ovf=%b want 9 1", c_live, c_lovf);
        else passed++;
      end
    end
    total++;
    if ({c_res, c_rovf} !== {4'h9, 1'b1})
      $display("FAIL sat result: got res=%h rovf=%b want 9 1", c_res, c_rovf);
    else passed++;
    total++;
    if ({c_live, c_lovf, c_pd} !== {4'h0, 1'b0, 1'b1})
      $display("FAIL sat clear: got live=%h lovf=%b pd=%b want 0 0 1", c_live, c_lovf, c_pd);
    else passed++;
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1);
    total++;
    if ({a_lfsr, a_match, a_live} !== {4'h5, 1'b1, 16'h0001})
      $display("FAIL hold pre: got lfsr=%h match=%b live=%h want 5 1 0001", a_lfsr, a_match,
               a_live);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      total++;
      if ({a_lfsr, a_match, a_pd, a_live, a_res} !== {4'h5, 1'b0, 1'b0, 16'h0001, 16'h0000})
        $display("FAIL hold idle %0d: got lfsr=%h match=%b pd=%b live=%h res=%h want 5 0 0 0001 0000",
                 i, a_lfsr, a_match, a_pd, a_live, a_res);
      else passed++;
    end
    for (int i = 9; i <= 15; i++) step(1'b1);
    total++;
    if ({a_lfsr, a_pd, a_res, a_live} !== {4'h1, 1'b1, 16'h0004, 16'h0000})
      $display("FAIL hold resume: got lfsr=%h pd=%b res=%h live=%h want 1 1 0004 0000",
               a_lfsr, a_pd, a_res, a_live);
    else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 25; i++) step(1'b1);
    total++;
    if ({a_res, a_live} !== {16'h0004, 16'h0001})
      $display("FAIL midreset pre: got res=%h live=%h want 0004 0001", a_res, a_live);
    else passed++;
    reset = 1'b1;
    tick  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b0;
    total++;
    if ({a_lfsr, a_live, a_res, a_pd, a_match} !== {4'h1, 16'h0000, 16'h0000, 1'b0, 1'b0})
      $display("FAIL midreset: got lfsr=%h live=%h res=%h pd=%b match=%b want 1 0 0 0 0",
               a_lfsr, a_live, a_res, a_pd, a_match);
    else passed++;
    run_period_a("replay");
  endtask

  task automatic test_zero_seed();
    do_reset();
    total++;
    if (d_lfsr !== 4'b0001) $display("FAIL zeroseed reset: got %b want 0001", d_lfsr);
    else passed++;
    step(1'b1);
    total++;
    if (d_lfsr !== 4'b0010) $display("FAIL zeroseed tick: got %b want 0010", d_lfsr);
    else passed++;
    force dut_d.lfsr_q = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    release dut_d.lfsr_q;
    total++;
    if (d_lfsr !== 4'b0000) $display("FAIL zeroseed forced: got %b want 0000", d_lfsr);
    else passed++;
    step(1'b1);
    total++;
    if (d_lfsr !== 4'b0001) $display("FAIL zeroseed recover: got %b want 0001", d_lfsr);
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_overlap();
    test_non_overlap();
    test_saturate();
    test_hold();
    test_mid_reset();
    test_zero_seed();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
